// File: rtl/tia_pkg.sv
// tia_pkg: horizontal decode constants and reset values shared by the TIA blocks
package tia_pkg;

    localparam logic [5:0] SHS  = 6'b111100;
    localparam logic [5:0] RHS  = 6'b110111;
    localparam logic [5:0] RCB  = 6'b001111;
    localparam logic [5:0] RHB  = 6'b011100;
    localparam logic [5:0] LRHB = 6'b010111;
    localparam logic [5:0] CNT  = 6'b101100;
    localparam logic [5:0] END  = 6'b010100;
    localparam logic [5:0] ERR  = 6'b111111;

    localparam logic HSYNC_RST  = 1'b0;
    localparam logic HBLANK_RST = 1'b1;
    localparam logic CBURST_RST = 1'b0;
    localparam logic LATE_RST   = 1'b0;
    localparam logic CNT_RST    = 1'b0;
    localparam logic END_RST    = 1'b0;

endpackage

// File: rtl/tia_horizontal_decode_if.sv
// tia_horizontal_decode_if: counter-side inputs and timing outputs of the horizontal decoder
interface tia_horizontal_decode_if;

    logic       tick;
    logic [5:0] hcount;
    logic       shb;
    logic       hmove_strobe;
    logic       hsync;
    logic       hblank;
    logic       cburst;
    logic       late_hblank;
    logic       cnt_pulse;
    logic       end_pulse;

    modport master (
        output tick, hcount, shb, hmove_strobe,
        input  hsync, hblank, cburst, late_hblank, cnt_pulse, end_pulse
    );

    modport slave (
        input  tick, hcount, shb, hmove_strobe,
        output hsync, hblank, cburst, late_hblank, cnt_pulse, end_pulse
    );

endinterface

// File: rtl/tia_sr_latch.sv
// tia_sr_latch: enable-qualified set/reset flop with async reset value and selectable priority
module tia_sr_latch #(
    parameter logic RST_VAL  = 1'b0,
    parameter bit   SET_PRIO = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic set,
    input  logic clr,
    output logic q
);

    // Hold unless enabled; on a set/clear collision the parameter picks the winner
    always_ff @(posedge clk or posedge reset)
        if (reset)
            q <= RST_VAL;
        else if (en)
            q <= SET_PRIO ? (set | (q & ~clr)) : (~clr & (set | q));

endmodule

// File: rtl/tia_horizontal_decode.sv
// tia_horizontal_decode: turns the horizontal LFSR count into sync, blank, burst and line strobes
module tia_horizontal_decode
    import tia_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    tia_horizontal_decode_if.slave bus
);

    logic at_end;
    logic hb_clr;
    logic late_clr;

    assign at_end   = bus.shb | (bus.hcount == END) | (bus.hcount == ERR);
    assign hb_clr   = bus.late_hblank ? (bus.hcount == LRHB) : (bus.hcount == RHB);
    assign late_clr = bus.tick & bus.late_hblank & (bus.hcount == LRHB);

    tia_sr_latch #(.RST_VAL(HSYNC_RST), .SET_PRIO(1'b1)) u_hsync (
        .clk(clk), .reset(reset), .en(bus.tick),
        .set(bus.hcount == SHS), .clr(bus.hcount == RHS), .q(bus.hsync)
    );

    tia_sr_latch #(.RST_VAL(HBLANK_RST), .SET_PRIO(1'b1)) u_hblank (
        .clk(clk), .reset(reset), .en(bus.tick),
        .set(at_end), .clr(hb_clr), .q(bus.hblank)
    );

    tia_sr_latch #(.RST_VAL(CBURST_RST), .SET_PRIO(1'b1)) u_cburst (
        .clk(clk), .reset(reset), .en(bus.tick),
        .set(bus.hcount == RHS), .clr(bus.hcount == RCB), .q(bus.cburst)
    );

    // HMOVE can land on any clock, so this latch is always enabled and qualifies its clear itself
    tia_sr_latch #(.RST_VAL(LATE_RST), .SET_PRIO(1'b1)) u_late (
        .clk(clk), .reset(reset), .en(1'b1),
        .set(bus.hmove_strobe), .clr(late_clr), .q(bus.late_hblank)
    );

    // Single-clock centre and end-of-line strobes, low on every non-qualifying edge
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.cnt_pulse <= CNT_RST;
            bus.end_pulse <= END_RST;
        end else begin
            bus.cnt_pulse <= bus.tick & (bus.hcount == CNT);
            bus.end_pulse <= bus.tick & at_end;
        end

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// tb_tia_horizontal_decode: randomized line walks and corner cases against a rule-level model
module tb_tia_horizontal_decode;
    import tia_pkg::*;

    logic clk = 1'b0;
    logic reset;
    tia_horizontal_decode_if bus();

    tia_horizontal_decode dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic m_hs, m_hb, m_cb, m_late, m_cnt, m_end;
    int n_hs, n_cb, n_hb, n_cnt, n_end;
    logic [5:0] seq[$];

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.hsync, bus.hblank, bus.cburst, bus.late_hblank, bus.cnt_pulse, bus.end_pulse};
    endfunction

    task automatic reset_model();
        {m_hs, m_hb, m_cb, m_late, m_cnt, m_end} = {HSYNC_RST, HBLANK_RST, CBURST_RST, LATE_RST, CNT_RST, END_RST};
    endtask

    task automatic cyc(input logic t, input logic [5:0] h, input logic s, input logic hm);
        logic hb_off;
        bus.tick = t;
        bus.hcount = h;
        bus.shb = s;
        bus.hmove_strobe = hm;
        @(posedge clk);
        hb_off = m_late ? (h == LRHB) : (h == RHB);
        m_cnt = t && h == CNT;
        m_end = t && (s || h == END || h == ERR);
        if (t) begin
            if (h == SHS) m_hs = 1'b1;
            if (h == RHS) begin
                m_hs = 1'b0;
                m_cb = 1'b1;
            end
            if (h == RCB) m_cb = 1'b0;
            if (m_end) m_hb = 1'b1;
            else if (hb_off) m_hb = 1'b0;
        end
        if (hm) m_late = 1'b1;
        else if (t && h == LRHB && m_late) m_late = 1'b0;
        #1;
        chk("outs", outs(), {m_hs, m_hb, m_cb, m_late, m_cnt, m_end});
        n_hs += bus.hsync;
        n_cb += bus.cburst;
        n_hb += bus.hblank;
        n_cnt += bus.cnt_pulse;
        n_end += bus.end_pulse;
    endtask

    task automatic tick_at(input logic [5:0] h, input logic s, input int hm_sub);
        for (int k = 0; k < 4; k++) cyc(k == 0, h, s && k == 0, hm_sub == k);
    endtask

    task automatic run_line(input int hm_idx, input int hm_sub, input int exp_hb, input logic exp_late);
        {n_hs, n_cb, n_hb, n_cnt, n_end} = '0;
        for (int i = 0; i < seq.size(); i++) begin
            tick_at(seq[i], (i == seq.size() - 1) && $urandom_range(0, 1) == 1, i == hm_idx ? hm_sub : -1);
            if (i == hm_idx) chk("late_set", bus.late_hblank, 1);
            if (i == 18 && hm_idx == 18) chk("lrhb_hb_fall", bus.hblank, 0);
        end
        chk("hsync_len", n_hs, 16);
        chk("cburst_len", n_cb, 16);
        chk("hblank_len", n_hb, exp_hb);
        chk("cnt_len", n_cnt, 1);
        chk("end_len", n_end, 1);
        chk("late_eol", bus.late_hblank, exp_late);
    endtask

    initial begin
        logic [5:0] x;
        logic hs0, cb0;
        logic [5:0] pool[8];
        pool = '{SHS, RHS, RCB, RHB, LRHB, CNT, END, ERR};
        x = '0;
        do begin
            seq.push_back(x);
            if (x == END) break;
            x = {~(x[0] ^ x[1]), x[5:1]};
        end while (seq.size() < 64);
        chk("line_len", seq.size(), 57);

        reset = 1'b1;
        {bus.tick, bus.hcount, bus.shb, bus.hmove_strobe} = '0;
        reset_model();
        #12;
        chk("reset_outs", outs(), 6'b010000);
        @(negedge clk);
        reset = 1'b0;

        run_line(-1, 0, 68, 1'b0);
        run_line($urandom_range(20, 50), $urandom_range(1, 3), 68, 1'b1);
        run_line(18, 0, 76, 1'b1);
        run_line(-1, 0, 76, 1'b0);

        for (int i = 0; i <= 20; i++) tick_at(seq[i], 1'b0, -1);
        hs0 = bus.hsync;
        cb0 = bus.cburst;
        chk("pre_err_hb", bus.hblank, 0);
        cyc(1'b1, ERR, 1'b0, 1'b0);
        chk("err_hb", bus.hblank, 1);
        chk("err_end", bus.end_pulse, 1);
        chk("err_hs", bus.hsync, hs0);
        chk("err_cb", bus.cburst, cb0);
        cyc(1'b0, ERR, 1'b0, 1'b0);
        chk("err_end_drop", bus.end_pulse, 0);

        for (int i = 0; i < 5; i++) cyc(1'b0, SHS, 1'b0, 1'b0);
        chk("shs_notick", bus.hsync, 0);
        cyc(1'b1, SHS, 1'b0, 1'b0);
        chk("shs_tick", bus.hsync, 1);

        for (int i = 0; i < 6; i++) tick_at(seq[i], 1'b0, i == 2 ? 1 : -1);
        chk("pre_rst_hs", bus.hsync, 1);
        chk("pre_rst_late", bus.late_hblank, 1);
        #2;
        reset = 1'b1;
        #1;
        reset_model();
        chk("async_rst", outs(), 6'b010000);
        #1;
        reset = 1'b0;
        run_line(-1, 0, 68, 1'b0);

        for (int i = 0; i < 400; i++) begin
            x = $urandom_range(0, 1) == 1 ? pool[$urandom_range(0, 7)] : 6'($urandom);
            cyc(1'b1, x, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            for (int g = $urandom_range(0, 4); g > 0; g--)
                cyc(1'b0, 6'($urandom), 1'b0, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tia_horizontal_decode.md
# tia_horizontal_decode

Decodes the horizontal LFSR count into the TIA's horizontal timing signals: HSYNC, HBLANK, colour burst, centre and end-of-line strobes, plus the HMOVE late-blank extension. It consumes the 6-bit count and `shb` from the horizontal counter, and drives the sync/blank mixer and the object motion logic. Internally it holds a small bank of set/reset latches that are updated only on counter-advance ticks.

## Interface
Parameters: none. All decode values are fixed package constants.

Ports:
- `clk`  in  1  master colour clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-`clk`-wide enable marking the cycle in which the LFSR value on `hcount` is valid for decode. Asserted once per 4 `clk` cycles.
- `hcount`  in  6  horizontal LFSR value, bit 5 = MSB.
- `shb`  in  1  counter reset / start-of-blank indication from the horizontal counter.
- `hmove_strobe`  in  1  one-`clk` pulse from an HMOVE register write.
- `hsync`  out  1  horizontal sync.
- `hblank`  out  1  horizontal blank.
- `cburst`  out  1  colour-burst window.
- `late_hblank`  out  1  HMOVE extension latch. When high, blank ends at LRHB instead of RHB.
- `cnt_pulse`  out  1  one-`clk` strobe at line centre.
- `end_pulse`  out  1  one-`clk` strobe at line end / `shb`.

## Operation
- Decode constants, `hcount[5:0]`:
  - SHS = 111100: set HSYNC.
  - RHS = 110111: reset HSYNC.
  - RCB = 001111: reset colour burst.
  - RHB = 011100: reset HBLANK.
  - LRHB = 010111: late reset of HBLANK.
  - CNT = 101100: centre.
  - END = 010100: end of line.
  - ERR = 111111: lock-up state.
- State and strobe updates happen only on `clk` edges where `tick`=1. The only exception is the `late_hblank` set.
- On a tick, the following updates apply:
  - `shb`=1, or `hcount` equals END or ERR: `hblank`<=1 and `end_pulse`<=1.
  - `hcount`=SHS: `hsync`<=1.
  - `hcount`=RHS: `hsync`<=0 and `cburst`<=1.
  - `hcount`=RCB: `cburst`<=0.
  - `hcount`=RHB and `late_hblank`=0: `hblank`<=0.
  - `hcount`=LRHB and `late_hblank`=1: `hblank`<=0 and `late_hblank`<=0.
  - `hcount`=CNT: `cnt_pulse`<=1.
- `hblank` priority: a set caused by `shb`/END/ERR wins over any reset in the same tick.
- `late_hblank`:
  - Set on any `clk` edge with `hmove_strobe`=1, independent of `tick`.
  - Cleared only as described under LRHB above.
  - If a set and a clear occur on the same edge, the set wins. HMOVE issued at LRHB therefore extends the next line.
- `cnt_pulse` and `end_pulse` are high for exactly one `clk` cycle and are cleared on every non-qualifying edge.
- All other `hcount` values leave the latches unchanged. Any value outside the constants above has no effect.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values: `hsync`=0, `hblank`=1, `cburst`=0, `late_hblank`=0, `cnt_pulse`=0, `end_pulse`=0.
- Reset is asynchronous. Asserting it mid-line forces the reset values immediately, and decode resumes on the first tick after release.
- Latency: an output changes on the same `clk` edge that samples `tick`=1 with the matching `hcount`, so it is visible one cycle after the tick cycle.
- Over a full 57-tick line (228 `clk`), with no HMOVE:
  - `hsync` is high for 4 ticks (16 `clk`).
  - `cburst` is high for 4 ticks.
  - `hblank` is high from END to RHB: 17 ticks = 68 `clk`.
- With HMOVE, `hblank` is held 2 ticks (8 `clk`) longer.

## Structure
- Shared package `tia_pkg` holds:
  - the 6-bit decode constants SHS, RHS, RCB, RHB, LRHB, CNT, END, ERR;
  - the reset-value constants.
- One sub-module is natural: `tia_sr_latch`, a tick-qualified set/reset flop with async reset value and a set-priority parameter. Instantiate it once each for `hsync`, `hblank`, `cburst`, and `late_hblank`.
- The rest is the decode comparators and the two strobe flops in the top level.

## Test plan
- Reset, then 57 ticks walking the real LFSR sequence:
  - `hsync` rises at the tick after SHS and falls after RHS;
  - `cburst` is high RHS→RCB;
  - `hblank` falls after RHB;
  - `cnt_pulse` and `end_pulse` are each high for exactly 1 `clk`.
- `hmove_strobe` pulsed mid-line:
  - `late_hblank`=1 immediately;
  - on the next line, `hblank` ignores RHB and falls after LRHB (8 `clk` later);
  - `late_hblank` returns to 0 at that same edge.
- `hmove_strobe` on the same edge as the LRHB tick: `hblank` falls, `late_hblank` stays 1, and the following line is also extended.
- `hcount`=ERR (111111) on a tick while `hblank`=0: `hblank`=1, `end_pulse`=1, and `hsync`/`cburst` are unchanged.
- `hcount`=SHS presented with `tick`=0 for several cycles: no output changes. Assert `tick` once: `hsync`=1.
- `reset` asserted between SHS and RHS, with `hsync`=1 and `late_hblank`=1: all outputs immediately return to their reset values, with `hblank`=1.
